// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: registered single-cycle ops plus an iterative shift-add multiply, valid/ready on both sides.
// Define ALU_EXEC_FAST_MUL_EN to replace the iterative multiply with a single-cycle array product.
//
// state | meaning
// IDLE  | waiting for an operation; single-cycle ops complete here
// MUL   | shift-add multiply iterating, one multiplier bit per clock
module alu_exec_unit #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_control,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            branch_taken,
    output logic            busy
);

    localparam logic [3:0] OP_MUL = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SLL = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_BEQ = 4'd5;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_BGE = 4'd7;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] MUL  = 1'b1;

    localparam int            CW   = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    logic [0:0]      state;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [CW-1:0]   count;

    logic            accept;
    logic            start_mul;
    logic [XLEN-1:0] diff;
    logic [XLEN-1:0] alu_res;
    logic            alu_zero;
    logic            alu_bt;
    logic [XLEN-1:0] acc_next;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign diff     = src_a - src_b;

    always_comb begin
        alu_res = '0;
        alu_bt  = 1'b0;
        case (alu_control)
            OP_ADD: alu_res = src_a + src_b;
            OP_SUB: alu_res = diff;
            OP_XOR: alu_res = src_a ^ src_b;
            OP_SLL: alu_res = src_a << src_b[SHW-1:0];
            OP_BEQ: begin
                alu_res = diff;
                alu_bt  = (src_a == src_b);
            end
            OP_BGE: begin
                alu_res = diff;
                alu_bt  = ($signed(src_a) >= $signed(src_b));
            end
`ifdef ALU_EXEC_FAST_MUL_EN
            OP_MUL: alu_res = src_a * src_b;
`endif
            default: alu_res = '0;
        endcase
    end

    // For beq/bge the result is a-b, so result==0 is exactly a==b; NOPs give 0 and hence zero=1.
    assign alu_zero = (alu_res == '0);

`ifdef ALU_EXEC_FAST_MUL_EN
    assign start_mul = 1'b0;
    assign busy      = 1'b0;
`else
    assign start_mul = (alu_control == OP_MUL);
    assign busy      = (state == MUL);
`endif

    assign acc_next = mplier[0] ? (acc + mcand) : acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            out_valid    <= 1'b0;
            result       <= '0;
            zero         <= 1'b0;
            branch_taken <= 1'b0;
            acc          <= '0;
            mcand        <= '0;
            mplier       <= '0;
            count        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (start_mul) begin
                            state     <= MUL;
                            out_valid <= 1'b0;
                            acc       <= '0;
                            mcand     <= src_a;
                            mplier    <= src_b;
                            count     <= '0;
                        end else begin
                            out_valid    <= 1'b1;
                            result       <= alu_res;
                            zero         <= alu_zero;
                            branch_taken <= alu_bt;
                        end
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (count == LAST) begin
                        state        <= IDLE;
                        out_valid    <= 1'b1;
                        result       <= acc_next;
                        zero         <= (acc_next == '0);
                        branch_taken <= 1'b0;
                        count        <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: vector table through a result scoreboard, plus multiply, backpressure and reset sequences.
module tb_alu_exec_unit;

    localparam int XLEN = 32;
`ifdef ALU_EXEC_FAST_MUL_EN
    localparam int MUL_CYC = 0;
`else
    localparam int MUL_CYC = XLEN;
`endif

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_control;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            branch_taken;
    logic            busy;

    alu_exec_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_control(alu_control), .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .branch_taken(branch_taken), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] res;
        logic            z;
        logic            bt;
    } exp_t;

    typedef struct {
        logic [3:0]      code;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] res;
        logic            z;
        logic            bt;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard consumer: every output handshake must match the oldest outstanding op.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_output: got %h expected none", result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", 64'(result), 64'(e.res));
                chk("zero", 64'(zero), 64'(e.z));
                chk("branch_taken", 64'(branch_taken), 64'(e.bt));
            end
        end
    end

    task automatic send(input logic [3:0] c, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] er, input logic ez, input logic ebt);
        bit   done;
        exp_t e;
        done        = 1'b0;
        alu_control = c;
        src_a       = a;
        src_b       = b;
        in_valid    = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                e.res = er;
                e.z   = ez;
                e.bt  = ebt;
                sb.push_back(e);
                done = 1'b1;
            end else begin
                @(posedge clk);
            end
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got in_ready=0 expected accept within 200 cycles");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl.push_back('{4'd2, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0});
        tbl.push_back('{4'd6, 32'd7,        32'd7,        32'd0,        1'b1, 1'b0});
        tbl.push_back('{4'd2, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0});
        tbl.push_back('{4'd7, 32'hFFFFFFFD, 32'd2,        32'hFFFFFFFB, 1'b0, 1'b0});
        tbl.push_back('{4'd7, 32'd2,        32'hFFFFFFFD, 32'd5,        1'b0, 1'b1});
        tbl.push_back('{4'd7, 32'd5,        32'd5,        32'd0,        1'b1, 1'b1});
        tbl.push_back('{4'd5, 32'h1234,     32'h1234,     32'd0,        1'b1, 1'b1});
        tbl.push_back('{4'd5, 32'd5,        32'd3,        32'd2,        1'b0, 1'b0});
        tbl.push_back('{4'd3, 32'd1,        32'h21,       32'd2,        1'b0, 1'b0});
        tbl.push_back('{4'd3, 32'h80000001, 32'd31,       32'h80000000, 1'b0, 1'b0});
        tbl.push_back('{4'd4, 32'hF0,       32'hFF,       32'h0F,       1'b0, 1'b0});
        tbl.push_back('{4'd0, 32'd5,        32'd6,        32'd0,        1'b1, 1'b0});
        tbl.push_back('{4'd12, 32'd9,       32'd9,        32'd0,        1'b1, 1'b0});
        tbl.push_back('{4'd1, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 1'b0, 1'b0});
        tbl.push_back('{4'd1, 32'h10000,    32'h10000,    32'd0,        1'b1, 1'b0});
        tbl.push_back('{4'd1, 32'h12345678, 32'd9,        32'hA3D70A38, 1'b0, 1'b0});
        tbl.push_back('{4'd2, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1'b0});

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        alu_control = 4'd0;
        src_a       = '0;
        src_b       = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_zero", 64'(zero), 64'd0);
        chk("rst_branch", 64'(branch_taken), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // add latency: output visible right after the accept edge
        send(4'd2, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
        @(negedge clk);
        chk("add_latency", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;

        foreach (tbl[i])
            send(tbl[i].code, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].z, tbl[i].bt);
        repeat (2) @(posedge clk);
        #1;

        // multiply 6*7: busy and stalled for the full iteration
        send(4'd1, 32'd6, 32'd7, 32'd42, 1'b0, 1'b0);
        for (int c = 0; c < MUL_CYC; c++) begin
            @(negedge clk);
            chk("mul_busy", 64'(busy), 64'd1);
            chk("mul_in_ready", 64'(in_ready), 64'd0);
            chk("mul_out_valid", 64'(out_valid), 64'd0);
            @(posedge clk);
        end
        @(negedge clk);
        chk("mul_done_valid", 64'(out_valid), 64'd1);
        chk("mul_done_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        #1;

        // backpressure: xor result held while downstream stalls
        out_ready = 1'b0;
        send(4'd4, 32'hF0, 32'hFF, 32'h0F, 1'b0, 1'b0);
        repeat (5) begin
            @(negedge clk);
            chk("hold_result", 64'(result), 64'h0F);
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(4'd2, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);
        @(negedge clk);
        chk("b2b_valid", 64'(out_valid), 64'd1);
        chk("b2b_result", 64'(result), 64'd2);
        repeat (2) @(posedge clk);
        #1;

        // reset in the middle of a multiply
        send(4'd1, 32'd6, 32'd7, 32'd42, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_result", 64'(result), 64'd0);
        chk("midrst_zero", 64'(zero), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("postrst_no_output", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        send(4'd2, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0);
        @(negedge clk);
        chk("postrst_latency", 64'(out_valid), 64'd1);
        chk("postrst_result", 64'(result), 64'd7);

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
